bcd_count_ctrl: RTL

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

---
 rtl/bcd_count_ctrl_pkg.sv | 23 ++
 rtl/bcd_count_ctrl_bin2bcd_7.sv | 29 ++
 rtl/bcd_count_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD count controller.
//   state_t      - controller state encoding
//   BCD_MAX      - largest target a two-digit BCD counter can reach
//   bcd_digit_t  - one BCD digit
//   sat_bcd_max  - clamps a 7-bit binary target to BCD_MAX
package bcd_count_ctrl_pkg;

  localparam int BCD_MAX = 99;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [6:0] sat_bcd_max(input logic [6:0] val);
    return (val > 7'(BCD_MAX)) ? 7'(BCD_MAX) : val;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_bin2bcd_7.sv
// Combinational 7-bit binary (0..99) to two-digit BCD conversion.
// Ports:
//   bin  in  7  binary value, expected range 0..99
//   tens out 4  BCD tens digit
//   ones out 4  BCD ones digit
// Values above 99 are not expected; the tens digit saturates at 9.
module bin2bcd_7
  import bcd_count_ctrl_pkg::*;
(
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd_digit_t tens_v;

  // Threshold ladder instead of a divider: pick the largest multiple of
  // ten not exceeding bin, the remainder is the ones digit.
  always_comb begin
    tens_v = '0;
    for (int i = 1; i <= 9; i++) begin
      if (bin >= 7'(i * 10)) tens_v = 4'(i);
    end
  end

  assign tens = tens_v;
  assign ones = 4'(bin - 7'(10 * int'(tens_v)));

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencer for an external two-digit BCD counter.
// Accepts a count target, loads it into the counter, runs the counter
// until its digits match the target, then holds the result briefly.
// A timer flags a sticky timeout if no match occurs in time.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | ready for a request; counter held clear
// ST_LOAD  | one cycle with cnt_run=0 so the counter loads cnt_max
// ST_COUNT | counter running; watching digits and timer
// ST_DONE  | match seen; counter holds for HOLD_CYC cycles
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   new target presented
//   req_max    in 7 requested maximum count (binary, clamped to 99)
//   req_ready  out  request accepted when req_valid is high
//   abort      in   terminate the current run
//   digit_1    in 4 counter ones digit
//   digit_2    in 4 counter tens digit
//   cnt_run    out  counter run enable (0 clears/loads)
//   cnt_max    out 7 target to the counter
//   busy       out  high in LOAD, COUNT and DONE
//   done       out  one-cycle pulse on match
//   timeout    out  sticky timeout flag, cleared on next accept
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int TMO_CYC  = 127,
  parameter int HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [6:0] req_max,
  output logic       req_ready,
  input  logic       abort,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  output logic       cnt_run,
  output logic [6:0] cnt_max,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam logic [7:0] TMO_LAST  = 8'(TMO_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [7:0] hold, hold_n;
  logic [6:0] tgt, tgt_n;
  bcd_digit_t tgt_tens, tgt_tens_n;
  bcd_digit_t tgt_ones, tgt_ones_n;
  logic       done_n, timeout_n;
  logic       req_ready_n, cnt_run_n, busy_n;

  logic [6:0] req_sat;
  bcd_digit_t req_tens, req_ones;
  logic       match;

  assign req_sat = sat_bcd_max(req_max);

  bin2bcd_7 u_bin2bcd (
    .bin  (req_sat),
    .tens (req_tens),
    .ones (req_ones)
  );

  // Non-BCD digits are excluded explicitly so a corrupted counter can
  // never produce a false match.
  assign match = (digit_1 <= 4'd9) && (digit_2 <= 4'd9) &&
                 (digit_2 == tgt_tens) && (digit_1 == tgt_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      hold      <= '0;
      tgt       <= '0;
      tgt_tens  <= '0;
      tgt_ones  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      req_ready <= 1'b1;
      cnt_run   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      hold      <= hold_n;
      tgt       <= tgt_n;
      tgt_tens  <= tgt_tens_n;
      tgt_ones  <= tgt_ones_n;
      done      <= done_n;
      timeout   <= timeout_n;
      req_ready <= req_ready_n;
      cnt_run   <= cnt_run_n;
      busy      <= busy_n;
    end
  end

  assign cnt_max = tgt;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    hold_n     = hold;
    tgt_n      = tgt;
    tgt_tens_n = tgt_tens;
    tgt_ones_n = tgt_ones;
    done_n     = 1'b0;
    timeout_n  = timeout;

    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (req_valid) begin
          state_n    = ST_LOAD;
          tgt_n      = req_sat;
          tgt_tens_n = req_tens;
          tgt_ones_n = req_ones;
          timeout_n  = 1'b0;
        end
      end
      ST_LOAD: begin
        timer_n = '0;
        state_n = abort ? ST_IDLE : ST_COUNT;
      end
      ST_COUNT: begin
        // Priority: abort, then match, then timer expiry.
        if (abort) begin
          state_n = ST_IDLE;
        end else if (match) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          hold_n  = HOLD_LAST;
        end else if (timer == TMO_LAST) begin
          state_n   = ST_IDLE;
          timeout_n = 1'b1;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      ST_DONE: begin
        if (abort || hold == '0) begin
          state_n = ST_IDLE;
        end else begin
          hold_n = hold - 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_n = (state_n == ST_IDLE);
    cnt_run_n   = (state_n == ST_COUNT) || (state_n == ST_DONE);
    busy_n      = (state_n != ST_IDLE);
  end

endmodule
